// File: rtl/softmax_pkg.sv
// Shared widths, FSM state type and helpers for the softmax divide sequencer.
package softmax_pkg;

    localparam int unsigned EXP_W = 16;    // S5.10 exp value / probability
    localparam int unsigned SUM_W = 24;    // S13.10 accumulated sum

    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } state_t;

    // Negative exp values contribute nothing to the distribution.
    function automatic logic [EXP_W-1:0] clamp_neg(input logic [EXP_W-1:0] x);
        return x[EXP_W-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/softmax_div_sequencer_if.sv
// Input stream, divider request/response and result stream of the softmax sequencer.
interface softmax_div_sequencer_if;
    import softmax_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [EXP_W-1:0]   in_data;
    logic               in_last;

    logic               div_start;
    logic [EXP_W-1:0]   div_num;
    logic [SUM_W-1:0]   div_den;
    logic               div_valid;
    logic [EXP_W-1:0]   div_quot;

    logic               out_valid;
    logic               out_ready;
    logic [EXP_W-1:0]   out_data;
    logic               out_last;

    modport master (
        output in_valid, in_data, in_last, div_valid, div_quot, out_ready,
        input  in_ready, div_start, div_num, div_den, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, div_valid, div_quot, out_ready,
        output in_ready, div_start, div_num, div_den, out_valid, out_data, out_last
    );

endinterface

// File: rtl/softmax_exp_buf.sv
// Single-port element store: synchronous write, combinational read, no reset.
module softmax_exp_buf
    import softmax_pkg::*;
#(
    parameter int unsigned N_MAX = 64,
    parameter int unsigned AW    = $clog2(N_MAX)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [AW-1:0]       i_addr,
    input  logic [EXP_W-1:0]    i_wdata,
    output logic [EXP_W-1:0]    o_rdata
);

    logic [EXP_W-1:0] r_mem [N_MAX];

    // Write port.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/softmax_div_sequencer.sv
// Softmax divide sequencer: buffers a vector of exp values, accumulates their sum,
// then issues one divide per element and streams the quotients out.
// Optional build macro SOFTMAX_SUM_SAT_EN: saturate the sum instead of wrapping.
module softmax_div_sequencer
    import softmax_pkg::*;
#(
    parameter int unsigned N_MAX = 64,
    parameter int unsigned AW    = $clog2(N_MAX)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    softmax_div_sequencer_if.slave  bus,
    output logic                    o_busy,
    output logic                    o_sum_ovf
);

    localparam int unsigned CW     = AW + 1;     // holds len == N_MAX
    localparam int unsigned SUM_EW = SUM_W + 1;  // sum plus carry-out

    state_t             r_state,     w_state_nxt;
    logic [AW-1:0]      r_wr_idx,    w_wr_idx_nxt;
    logic [AW-1:0]      r_rd_idx,    w_rd_idx_nxt;
    logic [CW-1:0]      r_len,       w_len_nxt;
    logic [SUM_W-1:0]   r_sum,       w_sum_nxt;
    logic               r_sum_ovf,   w_sum_ovf_nxt;
    logic [EXP_W-1:0]   r_head,      w_head_nxt;
    logic               r_in_ready,  w_in_ready_nxt;
    logic               r_div_start, w_div_start_nxt;
    logic [EXP_W-1:0]   r_div_num,   w_div_num_nxt;
    logic [SUM_W-1:0]   r_div_den,   w_div_den_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic [EXP_W-1:0]   r_out_data,  w_out_data_nxt;
    logic               r_out_last,  w_out_last_nxt;
    logic               r_busy,      w_busy_nxt;

    logic [EXP_W-1:0]   w_elem;
    logic               w_accept;
    logic [AW-1:0]      w_addr;
    logic [EXP_W-1:0]   w_rdata;
    logic [SUM_EW-1:0]  w_sum_add;

    assign w_elem    = clamp_neg(bus.in_data);
    assign w_accept  = bus.in_valid & r_in_ready;
    assign w_sum_add = {1'b0, r_sum} + SUM_EW'(w_elem);
    // The store is read only when leaving OUT, for the element after rd_idx.
    // Element 0 is kept in r_head since the port is busy writing on LOAD exit.
    assign w_addr    = (r_state == ST_OUT) ? (r_rd_idx + AW'(1)) : r_wr_idx;

    softmax_exp_buf #(
        .N_MAX (N_MAX),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_addr),
        .i_wdata (w_elem),
        .o_rdata (w_rdata)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_len       <= '0;
            r_sum       <= '0;
            r_sum_ovf   <= 1'b0;
            r_head      <= '0;
            r_in_ready  <= 1'b0;
            r_div_start <= 1'b0;
            r_div_num   <= '0;
            r_div_den   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_idx    <= w_wr_idx_nxt;
            r_rd_idx    <= w_rd_idx_nxt;
            r_len       <= w_len_nxt;
            r_sum       <= w_sum_nxt;
            r_sum_ovf   <= w_sum_ovf_nxt;
            r_head      <= w_head_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_div_start <= w_div_start_nxt;
            r_div_num   <= w_div_num_nxt;
            r_div_den   <= w_div_den_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_idx_nxt  = r_wr_idx;
        w_rd_idx_nxt  = r_rd_idx;
        w_len_nxt     = r_len;
        w_sum_nxt     = r_sum;
        w_sum_ovf_nxt = r_sum_ovf;
        w_head_nxt    = r_head;
        w_div_num_nxt = r_div_num;
        w_div_den_nxt = r_div_den;
        w_out_data_nxt = r_out_data;
        w_out_last_nxt = r_out_last;

        case (r_state)
            ST_IDLE, ST_LOAD: begin
                if (w_accept) begin
                    w_wr_idx_nxt = r_wr_idx + AW'(1);
                    w_sum_nxt    = w_sum_add[SUM_W-1:0];
                    if (w_sum_add[SUM_W]) begin
                        w_sum_ovf_nxt = 1'b1;
`ifdef SOFTMAX_SUM_SAT_EN
                        w_sum_nxt = SUM_MAX;
`endif
                    end
                    if (r_wr_idx == '0) begin
                        w_head_nxt = w_elem;
                    end
                    w_state_nxt = ST_LOAD;
                    if (bus.in_last || (r_wr_idx == AW'(N_MAX - 1))) begin
                        w_state_nxt   = ST_ISSUE;
                        w_rd_idx_nxt  = '0;
                        w_len_nxt     = CW'(r_wr_idx) + CW'(1);
                        w_div_num_nxt = (r_wr_idx == '0) ? w_elem : r_head;
                        w_div_den_nxt = w_sum_nxt;
                    end
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.div_valid) begin
                    w_out_data_nxt = bus.div_quot;
                    w_out_last_nxt = (CW'(r_rd_idx) == (r_len - CW'(1)));
                    w_state_nxt    = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    if (r_out_last) begin
                        w_sum_nxt     = '0;
                        w_wr_idx_nxt  = '0;
                        w_sum_ovf_nxt = 1'b0;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_rd_idx_nxt  = r_rd_idx + AW'(1);
                        w_div_num_nxt = w_rdata;
                        w_div_den_nxt = r_sum;
                        w_state_nxt   = ST_ISSUE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_in_ready_nxt  = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_LOAD);
        w_div_start_nxt = (w_state_nxt == ST_ISSUE);
        w_out_valid_nxt = (w_state_nxt == ST_OUT);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.div_start = r_div_start;
    assign bus.div_num   = r_div_num;
    assign bus.div_den   = r_div_den;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign o_busy        = r_busy;
    assign o_sum_ovf     = r_sum_ovf;

endmodule

// File: doc/softmax_div_sequencer.md
SOFTMAX_DIV_SEQUENCER -- requirements
Module: softmax_div_sequencer

Interface
REQ-001 Parameter N_MAX, default 64, maximum elements per vector (2..1024).
REQ-002 Parameter AW, default $clog2(N_MAX), buffer address width.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid/in_ready  in/out  1/1  input handshake; a beat transfers when both are high.
REQ-006 in_data  in  16  S5.10 exp value. in_last  in  1  final element of the vector.
REQ-007 div_start  out  1  single-cycle pulse to the downstream divider.
REQ-008 div_num  out  16  S5.10 numerator. div_den  out  24  S13.10 sum; both held stable from div_start until div_valid.
REQ-009 div_valid  in  1  divider done pulse. div_quot  in  16  S5.10 quotient.
REQ-010 out_valid/out_ready  out/in  1/1  result handshake. out_data  out  16  S5.10 probability. out_last  out  1  final result.
REQ-011 busy  out  1  high in any state other than IDLE. sum_ovf  out  1  sticky per-vector sum overflow flag.

Function
REQ-012 States: IDLE, LOAD, ISSUE, WAIT, OUT.
REQ-013 in_ready SHALL be 1 only in IDLE and LOAD; an accepted beat in IDLE moves to LOAD.
REQ-014 Each accepted beat SHALL be stored at buf[wr_idx]; wr_idx increments by one; sum += stored value, zero-extended to 24 bits.
REQ-015 Negative input (in_data[15]=1) SHALL be stored and summed as 0x0000.
REQ-016 Acceptance of in_last=1, or of the N_MAX-th beat, SHALL end loading; next state is ISSUE with rd_idx=0 and len=wr_idx+1.
REQ-017 ISSUE SHALL assert div_start for exactly one cycle with div_num=buf[rd_idx] and div_den=sum, then move to WAIT.
REQ-018 WAIT SHALL capture div_quot into out_data on div_valid and move to OUT on the same edge; div_valid outside WAIT is ignored.
REQ-019 OUT SHALL hold out_valid=1 and out_data stable until out_ready; out_last=1 when rd_idx==len-1.
REQ-020 On an OUT transfer: if last, clear sum, wr_idx and sum_ovf and go to IDLE; else increment rd_idx and go to ISSUE.
REQ-021 Per-element latency: div_start to out_valid = divider latency + 1 cycle; OUT to next div_start = 1 cycle after the transfer.
REQ-022 A zero sum SHALL still be issued; the divider's quotient is forwarded unmodified.

Reset
REQ-023 Reset SHALL force IDLE, sum=0, wr_idx=rd_idx=len=0, and sum_ovf=0.
REQ-024 Reset SHALL drive all outputs to 0 (in_ready=0 during reset, 1 after) and need not clear buffer contents.
REQ-025 Reset mid-vector SHALL discard the vector; no div_start or out_valid follows until new input arrives.

Configuration
REQ-026 Macro SOFTMAX_SUM_SAT_EN: when defined, a sum carry-out SHALL clamp the sum to 24'hFFFFFF and set sum_ovf.
REQ-027 When SOFTMAX_SUM_SAT_EN is undefined, the sum SHALL wrap modulo 2^24 and sum_ovf SHALL still set on carry-out.

Structure
REQ-028 Package softmax_pkg SHALL hold the S5.10/S13.10 width constants, the state enum and SUM_MAX.
REQ-029 The element store SHALL be the sub-module softmax_exp_buf: single-port, N_MAX x 16, synchronous write, combinational read.

Verification
REQ-030 Four beats 0x0400, last on the 4th, with a model divider -> four div_start pulses, div_num=0x0400, div_den=0x001000; out_data=0x0100 x4; out_last on the 4th.
REQ-031 A single beat 0x0800 with in_last=1 -> div_den=0x000800, one result, out_last=1, then IDLE with busy=0.
REQ-032 Beats 0x8400, 0x0400 (last) -> div_num sequence 0x0000, 0x0400; div_den=0x000400.
REQ-033 N_MAX=4 and 6 beats without in_last -> in_ready drops after the 4th beat; four results; out_last on the 4th.
REQ-034 out_ready low for 10 cycles in OUT -> out_data constant, no new div_start, and in_valid ignored.
REQ-035 N_MAX=1024, 1024 beats of 0x7FFF -> with the macro, div_den=0xFFFFFF and sum_ovf=1; without it, div_den=0xFFFC00 and sum_ovf=1; reset asserted in WAIT -> IDLE and all outputs 0.
